// File: rtl/vga_pkg.sv
// Shared constants for the frame-buffer scan-out block: default 640x480@60
// timing, frame-buffer geometry, clear-FSM state encoding and the
// row*160+col address helper used by both the write and read ports.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned CH_W     = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // row*160 + col without a multiplier: (row<<7) + (row<<5) + col
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] row,
                                                input logic [7:0] col);
    return (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_frame_scanout_if.sv
// Pixel-write bus between the drawing logic (master) and the scan-out
// block (slave).
//   x, y, colour : write coordinate and {r,g,b} data
//   plot         : one-pixel write strobe
//   clear        : pulse that starts the full-screen clear sweep
//   busy         : clear sweep in progress (driven by the slave)
interface vga_frame_scanout_if;
  import vga_pkg::*;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                clear;
  logic                busy;

  modport master (output x, y, colour, plot, clear, input busy);
  modport slave  (input x, y, colour, plot, clear, output busy);

endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator.
//   clk, reset         : system clock, synchronous active-high reset
//   pix_en             : toggles every clk; counters advance when it is 1
//   h_cnt, v_cnt       : raster position
//   hs_c, vs_c         : raw active-low syncs decoded from the counters
//   blank_n_c          : raw active-region flag decoded from the counters
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs_c,
  output logic             vs_c,
  output logic             blank_n_c
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;

  // Divide-by-two pixel enable and raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + CNT_W'(1);
          end
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Raw sync/blank decode; registered and delayed by the consumer
  always_comb begin
    hs_c      = ~((h_cnt >= CNT_W'(H_SYNC_LO)) && (h_cnt < CNT_W'(H_SYNC_HI)));
    vs_c      = ~((v_cnt >= CNT_W'(V_SYNC_LO)) && (v_cnt < CNT_W'(V_SYNC_HI)));
    blank_n_c = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  end

endmodule

// File: rtl/vga_frame_scanout.sv
// 160x120x3 frame buffer with a pixel-write port and a clear sweep,
// scanned out as VGA with each stored pixel replicated 4x4.
//   clk, reset                 : system clock, synchronous active-high reset
//   wr                         : pixel-write bus (x, y, colour, plot, clear, busy)
//   vga_r, vga_g, vga_b        : channel intensity, zero when blanked
//   vga_hs, vga_vs             : active-low syncs aligned with rgb
//   vga_blank_n                : high in the active region
//   vga_sync_n                 : tied low
//   vga_clk                    : pixel clock (half of clk)
module vga_frame_scanout
  import vga_pkg::*;
#(
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  vga_frame_scanout_if.slave  wr,
  output logic [CH_W-1:0]     vga_r,
  output logic [CH_W-1:0]     vga_g,
  output logic [CH_W-1:0]     vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic                vga_sync_n,
  output logic                vga_clk
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             hs_c;
  logic             vs_c;
  logic             blank_n_c;

  clr_state_t          state;
  clr_state_t          state_next;
  logic [ADDR_W-1:0]   clr_addr;
  logic [ADDR_W-1:0]   clr_addr_next;
  logic                plot_ok_c;
  logic                we_c;
  logic [ADDR_W-1:0]   wa_c;
  logic [COLOUR_W-1:0] wd_c;

  logic [COLOUR_W-1:0] mem [FB_DEPTH];
  logic [ADDR_W-1:0]   rd_addr;
  logic [COLOUR_W-1:0] rd_word_c;
  logic                hs_q;
  logic                vs_q;
  logic                blank_n_q;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hs_c      (hs_c),
    .vs_c      (vs_c),
    .blank_n_c (blank_n_c)
  );

  assign plot_ok_c = wr.plot && (wr.x < X_W'(FB_W)) && (wr.y < Y_W'(FB_H));

  // Clear FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      wr.busy  <= 1'b0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      wr.busy  <= (state_next == ST_CLEAR);
    end
  end

  // Clear FSM next state and write-port mux; clear beats a same-cycle plot
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    we_c          = 1'b0;
    wa_c          = fb_addr({1'b0, wr.y}, wr.x);
    wd_c          = wr.colour;
    case (state)
      ST_IDLE: begin
        if (wr.clear) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end else if (plot_ok_c) begin
          we_c = 1'b1;
        end
      end
      ST_CLEAR: begin
        we_c = 1'b1;
        wa_c = clr_addr;
        wd_c = BG_COLOUR;
        if (clr_addr == CLR_LAST) begin
          state_next    = ST_IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr + ADDR_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame buffer write port; contents are not touched by reset
  always_ff @(posedge clk) begin
    if (we_c && !reset) begin
      mem[wa_c] <= wd_c;
    end
  end

  assign rd_word_c = mem[rd_addr];

  // Scan stage 1: read address plus sync/blank, address held outside active
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr   <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      hs_q      <= hs_c;
      vs_q      <= vs_c;
      blank_n_q <= blank_n_c;
      if (blank_n_c) begin
        rd_addr <= fb_addr(8'(v_cnt >> 2), 8'(h_cnt >> 2));
      end
    end
  end

  // Scan stage 2: registered RAM read, colour expansion and aligned syncs
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= blank_n_q ? {CH_W{rd_word_c[2]}} : '0;
      vga_g       <= blank_n_q ? {CH_W{rd_word_c[1]}} : '0;
      vga_b       <= blank_n_q ? {CH_W{rd_word_c[0]}} : '0;
      vga_hs      <= hs_q;
      vga_vs      <= vs_q;
      vga_blank_n <= blank_n_q;
    end
  end

  assign vga_sync_n = 1'b0;
  assign vga_clk    = pix_en;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench for vga_frame_scanout on a shrunken raster (48x30 total,
// 32x24 active) so whole frames fit in a short run. A reference frame
// buffer plus an expected-output queue (two-cycle scan latency) checks the
// pins every cycle; sync, blank and busy pulse widths are measured too.
module tb_vga_frame_scanout;
  import vga_pkg::*;

  localparam int unsigned HA = 32, HF = 4, HSY = 8, HB = 4;
  localparam int unsigned VA = 24, VF = 2, VSY = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HSY + HB;
  localparam int unsigned VT = VA + VF + VSY + VB;
  localparam int unsigned FRAME = 2 * HT * VT;
  localparam logic [2:0]  BG = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

  vga_frame_scanout_if wr_if ();

  vga_frame_scanout #(
    .BG_COLOUR (BG),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr_if.slave),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .vga_clk     (vga_clk)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit         chk;
    logic       hs, vs, bn;
    logic [7:0] r, g, b;
  } exp_t;

  exp_t       sb[$];
  exp_t       rst_e;
  logic [2:0] fb [FB_DEPTH];
  bit         fb_known;
  bit         m_clear;
  int         m_caddr;
  int         k, cyc, errors, checks;
  int         hs_fall, vs_fall, bn_rise, busy_rise;
  logic       p_hs, p_vs, p_bn, p_busy;

  // Expected pins for raster position k (k counts clk cycles since reset)
  function automatic exp_t exp_at(int kk);
    exp_t e;
    int unsigned h, v;
    logic [2:0] d;
    bit act;
    h = (kk / 2) % HT;
    v = (kk / 2 / HT) % VT;
    act = (h < HA) && (v < VA);
    e.hs = !((h >= HA + HF) && (h < HA + HF + HSY));
    e.vs = !((v >= VA + VF) && (v < VA + VF + VSY));
    e.bn = act;
    e.chk = !act || fb_known;
    d = act ? fb[(v / 4) * 160 + h / 4] : 3'b000;
    e.r = {8{d[2]}};
    e.g = {8{d[1]}};
    e.b = {8{d[0]}};
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic seed();
    sb.delete();
    sb.push_back(rst_e);
    sb.push_back(rst_e);
    k = 0;
    m_clear = 1'b0;
    m_caddr = 0;
    hs_fall = -1;
    vs_fall = -1;
    bn_rise = -1;
    busy_rise = -1;
  endtask

  // One clk cycle: compare pins, drive inputs, advance the reference model
  task automatic step(bit rst, bit pl, int px, int py, logic [2:0] pc, bit cl);
    exp_t e;
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    check("vga_hs", 32'(vga_hs), 32'(e.hs));
    check("vga_vs", 32'(vga_vs), 32'(e.vs));
    check("vga_blank_n", 32'(vga_blank_n), 32'(e.bn));
    if (e.chk) begin
      check("vga_r", 32'(vga_r), 32'(e.r));
      check("vga_g", 32'(vga_g), 32'(e.g));
      check("vga_b", 32'(vga_b), 32'(e.b));
    end
    check("busy", 32'(wr_if.busy), 32'(m_clear));
    check("vga_clk", 32'(vga_clk), 32'(k % 2));
    check("vga_sync_n", 32'(vga_sync_n), 32'(0));

    if (p_hs === 1'b1 && vga_hs === 1'b0) begin
      if (hs_fall >= 0) check("hs_period", 32'(cyc - hs_fall), 32'(2 * HT));
      hs_fall = cyc;
    end
    if (p_hs === 1'b0 && vga_hs === 1'b1 && hs_fall >= 0)
      check("hs_low_width", 32'(cyc - hs_fall), 32'(2 * HSY));
    if (p_vs === 1'b1 && vga_vs === 1'b0) begin
      if (vs_fall >= 0) check("vs_period", 32'(cyc - vs_fall), 32'(FRAME));
      vs_fall = cyc;
    end
    if (p_vs === 1'b0 && vga_vs === 1'b1 && vs_fall >= 0)
      check("vs_low_width", 32'(cyc - vs_fall), 32'(2 * VSY * HT));
    if (p_bn === 1'b0 && vga_blank_n === 1'b1) bn_rise = cyc;
    if (p_bn === 1'b1 && vga_blank_n === 1'b0 && bn_rise >= 0)
      check("blank_n_high_width", 32'(cyc - bn_rise), 32'(2 * HA));
    if (p_busy === 1'b0 && wr_if.busy === 1'b1) busy_rise = cyc;
    if (p_busy === 1'b1 && wr_if.busy === 1'b0 && busy_rise >= 0)
      check("busy_width", 32'(cyc - busy_rise), 32'(FB_DEPTH));
    p_hs = vga_hs;
    p_vs = vga_vs;
    p_bn = vga_blank_n;
    p_busy = wr_if.busy;

    reset = rst;
    wr_if.plot = pl;
    wr_if.x = 8'(px);
    wr_if.y = 7'(py);
    wr_if.colour = pc;
    wr_if.clear = cl;

    if (rst) begin
      seed();
    end else begin
      if (m_clear) begin
        fb[m_caddr] = BG;
        if (m_caddr == int'(FB_DEPTH) - 1) begin
          m_clear = 1'b0;
          fb_known = 1'b1;
        end else begin
          m_caddr++;
        end
      end else if (cl) begin
        m_clear = 1'b1;
        m_caddr = 0;
      end else if (pl && px < 160 && py < 120) begin
        fb[py * 160 + px] = pc;
      end
      sb.push_back(exp_at(k));
      k++;
    end
  endtask

  task automatic run(int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, 3'b000, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    fb_known = 1'b0;
    reset = 1'b1;
    wr_if.plot = 1'b0;
    wr_if.clear = 1'b0;
    wr_if.x = '0;
    wr_if.y = '0;
    wr_if.colour = '0;
    rst_e.chk = 1'b1;
    rst_e.hs = 1'b1;
    rst_e.vs = 1'b1;
    rst_e.bn = 1'b0;
    rst_e.r = '0;
    rst_e.g = '0;
    rst_e.b = '0;

    // Reset held three cycles; first step checks reset values
    repeat (3) @(negedge clk);
    seed();
    p_hs = 1'b1;
    p_vs = 1'b1;
    p_bn = 1'b0;
    p_busy = 1'b0;

    // Free-run two frames for sync/blank timing
    run(2 * FRAME + 20);

    // Reset 100 cycles into a sweep, then a full sweep to completion
    step(1'b0, 1'b0, 0, 0, 3'b000, 1'b1);
    run(99);
    step(1'b1, 1'b0, 0, 0, 3'b000, 1'b0);
    run(5);
    step(1'b0, 1'b0, 0, 0, 3'b000, 1'b1);
    run(FB_DEPTH + 10);

    // Single plot at (5,3), scanned over a full frame
    step(1'b0, 1'b1, 5, 3, 3'b100, 1'b0);
    run(FRAME + 10);

    // Out-of-range plots must be dropped
    step(1'b0, 1'b1, 160, 0, 3'b111, 1'b0);
    step(1'b0, 1'b1, 0, 120, 3'b111, 1'b0);
    run(FRAME + 10);

    // Fill visible area, clear with a plot during busy, rescan
    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 8; xx++)
        step(1'b0, 1'b1, xx, yy, 3'((xx + yy) % 8), 1'b0);
    run(FRAME);
    step(1'b0, 1'b1, 7, 5, 3'b110, 1'b1);
    run(40);
    step(1'b0, 1'b1, 0, 0, 3'b010, 1'b0);
    run(FB_DEPTH);
    run(FRAME + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
